// File: rtl/cal_pkg.sv
// cal_pkg: shared types, widths and mask helpers for the calculator request initiator
package cal_pkg;
  localparam int TAG_W = 2;
  localparam int DATA_W = 32;
  localparam int CMD_W = 4;
  localparam int NTAG = 1 << TAG_W;
  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cal_cmd_e;
  typedef enum logic [1:0] {RESP_NONE, RESP_OK, RESP_ERR, RESP_TIMEOUT} cal_resp_e;
  typedef enum logic {IDLE, OP2} cal_state_e;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [CMD_W-1:0] cmd;
    logic [1:0] resp;
    logic [DATA_W-1:0] data;
  } cal_result_t;
  function automatic logic [TAG_W:0] popcount(input logic [NTAG-1:0] m);
    logic [TAG_W:0] n = '0;
    for (int i = 0; i < NTAG; i++) n += (TAG_W+1)'(m[i]);
    return n;
  endfunction
  function automatic logic [TAG_W-1:0] lowest_set(input logic [NTAG-1:0] m);
    logic [TAG_W-1:0] t = '0;
    for (int i = NTAG - 1; i >= 0; i--) if (m[i]) t = TAG_W'(i);
    return t;
  endfunction
endpackage

// File: rtl/cal_req_initiator_if.sv
// cal_req_initiator_if: operation, calculator request/response and result buses
interface cal_req_initiator_if;
  import cal_pkg::*;
  logic op_valid;
  logic op_ready;
  logic [CMD_W-1:0] op_cmd;
  logic [DATA_W-1:0] op_data1;
  logic [DATA_W-1:0] op_data2;
  logic [CMD_W-1:0] req_cmd;
  logic [TAG_W-1:0] req_tag;
  logic [DATA_W-1:0] req_data;
  logic [1:0] rsp_resp;
  logic [TAG_W-1:0] rsp_tag;
  logic [DATA_W-1:0] rsp_data;
  logic res_valid;
  logic res_ready;
  logic [TAG_W-1:0] res_tag;
  logic [CMD_W-1:0] res_cmd;
  logic [1:0] res_resp;
  logic [DATA_W-1:0] res_data;
  modport master (
    input op_valid, op_cmd, op_data1, op_data2, rsp_resp, rsp_tag, rsp_data, res_ready,
    output op_ready, req_cmd, req_tag, req_data, res_valid, res_tag, res_cmd, res_resp, res_data
  );
  modport slave (
    output op_valid, op_cmd, op_data1, op_data2, rsp_resp, rsp_tag, rsp_data, res_ready,
    input op_ready, req_cmd, req_tag, req_data, res_valid, res_tag, res_cmd, res_resp, res_data
  );
endinterface

// File: rtl/cal_req_initiator_res_fifo.sv
// cal_res_fifo: show-ahead result FIFO; the head entry is presented while not empty
module cal_res_fifo import cal_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cal_result_t din,
  input  logic pop,
  output cal_result_t dout,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  cal_result_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // upstream credit accounting keeps a push from ever meeting a full buffer
  assert property (@(posedge clk) disable iff (!reset) !(push && count == CW'(DEPTH) && !pop));
endmodule

// File: rtl/cal_req_initiator.sv
// cal_req_initiator: tags operations, drives two-cycle calculator requests, matches responses
module cal_req_initiator import cal_pkg::*; #(
  parameter int TIMEOUT = 100,
  parameter int RES_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  cal_req_initiator_if.master bus,
  output logic [TAG_W:0] outstanding,
  output logic err_unexpected,
  output logic err_timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(RES_DEPTH + 1);
  cal_state_e state, state_d;
  logic [NTAG-1:0] mask, mask_d, expired;
  logic [TW-1:0] timer [NTAG];
  logic [CMD_W-1:0] cmd_q [NTAG];
  logic [DATA_W-1:0] data2_q, req_data_d;
  logic [CMD_W-1:0] req_cmd_d;
  logic [TAG_W-1:0] req_tag_d, free_tag, exp_tag;
  logic [CW-1:0] fifo_count;
  logic accept, rsp_valid, rsp_hit, timeout_push, push, fifo_empty;
  cal_result_t push_entry, head;
  assign outstanding = popcount(mask);
  assign free_tag = lowest_set(~mask);
  // credit: every issued tag plus every buffered result must fit the result buffer
  assign bus.op_ready = reset && state == IDLE && !(&mask) && int'(outstanding) + int'(fifo_count) < RES_DEPTH;
  assign accept = bus.op_valid && bus.op_ready;
  assign rsp_valid = bus.rsp_resp != RESP_NONE;
  assign rsp_hit = rsp_valid && mask[bus.rsp_tag];
  always_comb
    for (int t = 0; t < NTAG; t++) expired[t] = mask[t] && timer[t] == TW'(TIMEOUT);
  assign exp_tag = lowest_set(expired);
  assign timeout_push = !rsp_hit && |expired;
  assign push = rsp_hit || timeout_push;
  assign push_entry = rsp_hit ? {bus.rsp_tag, cmd_q[bus.rsp_tag], bus.rsp_resp, bus.rsp_data}
                              : {exp_tag, cmd_q[exp_tag], RESP_TIMEOUT, DATA_W'(0)};
  always_comb begin
    mask_d = mask;
    if (accept) mask_d[free_tag] = 1'b1;
    if (rsp_hit) mask_d[bus.rsp_tag] = 1'b0;
    if (timeout_push) mask_d[exp_tag] = 1'b0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_d;
  always_comb state_d = (state == IDLE && accept) ? OP2 : IDLE;
  always_comb begin
    req_cmd_d = accept ? bus.op_cmd : '0;
    req_tag_d = accept ? free_tag : '0;
    req_data_d = state == OP2 ? data2_q : accept ? bus.op_data1 : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.req_cmd <= '0;
      bus.req_tag <= '0;
      bus.req_data <= '0;
    end else begin
      bus.req_cmd <= req_cmd_d;
      bus.req_tag <= req_tag_d;
      bus.req_data <= req_data_d;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mask <= '0;
      data2_q <= '0;
      err_unexpected <= 1'b0;
      err_timeout <= 1'b0;
      for (int t = 0; t < NTAG; t++) begin
        timer[t] <= '0;
        cmd_q[t] <= '0;
      end
    end else begin
      mask <= mask_d;
      err_unexpected <= rsp_valid && !mask[bus.rsp_tag];
      err_timeout <= timeout_push;
      for (int t = 0; t < NTAG; t++)
        timer[t] <= (mask[t] && mask_d[t]) ? timer[t] + TW'(timer[t] != TW'(TIMEOUT)) : '0;
      if (accept) begin
        cmd_q[free_tag] <= bus.op_cmd;
        data2_q <= bus.op_data2;
      end
    end
  cal_res_fifo #(.DEPTH(RES_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din(push_entry),
    .pop(bus.res_valid && bus.res_ready),
    .dout(head),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  assign bus.res_valid = !fifo_empty;
  assign {bus.res_tag, bus.res_cmd, bus.res_resp, bus.res_data} = head;
endmodule

// File: tb/tb_cal_req_initiator.sv
// tb_cal_req_initiator: table, directed and random checks against a queue-based reference model
module tb_cal_req_initiator;
  import cal_pkg::*;
  localparam int TMO = 8;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] outstanding;
  logic err_unexpected, err_timeout;
  int checks = 0;
  int errors = 0;
  cal_req_initiator_if bus();
  cal_req_initiator #(.TIMEOUT(TMO), .RES_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .outstanding(outstanding),
    .err_unexpected(err_unexpected),
    .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;

  // reference model: a set of in-flight tags with issue times plus a result queue
  bit m_op2;
  logic [31:0] m_d2;
  bit m_busy [4];
  logic [3:0] m_cmd [4];
  int m_issue [4];
  int cyc = 0;
  cal_result_t m_q [$];
  logic [3:0] e_req_cmd;
  logic [1:0] e_req_tag;
  logic [31:0] e_req_data;
  bit e_unexp, e_tmo;

  typedef struct {
    bit ov; logic [3:0] cmd; logic [31:0] d1; logic [31:0] d2;
    logic [1:0] rr; logic [1:0] rt; logic [31:0] rd; bit rdy;
    bit x_ordy; logic [3:0] x_rcmd; logic [1:0] x_rtag; logic [31:0] x_rdata;
    bit x_rv; logic [39:0] x_head; logic [2:0] x_out; bit x_unexp;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int n_busy();
    int n = 0;
    for (int t = 0; t < 4; t++) n += int'(m_busy[t]);
    return n;
  endfunction

  function automatic bit m_ready();
    return !m_op2 && n_busy() < 4 && n_busy() + m_q.size() < DEPTH;
  endfunction

  task automatic m_reset();
    m_op2 = 0;
    m_d2 = '0;
    for (int t = 0; t < 4; t++) begin
      m_busy[t] = 0;
      m_cmd[t] = '0;
      m_issue[t] = 0;
    end
    m_q.delete();
    e_unexp = 0;
    e_tmo = 0;
  endtask

  task automatic drive(input bit ov, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] rr, input logic [1:0] rt, input logic [31:0] rd, input bit rdy);
    bus.op_valid = ov;
    bus.op_cmd = c;
    bus.op_data1 = a;
    bus.op_data2 = b;
    bus.rsp_resp = rr;
    bus.rsp_tag = rt;
    bus.rsp_data = rd;
    bus.res_ready = rdy;
  endtask

  task automatic step();
    bit acc, rdy;
    int tag;
    logic [3:0] c;
    logic [31:0] a, b, rd;
    logic [1:0] rr, rt;
    cal_result_t r, head;
    acc = bus.op_valid && m_ready();
    tag = 0;
    for (int t = 3; t >= 0; t--) if (!m_busy[t]) tag = t;
    c = bus.op_cmd; a = bus.op_data1; b = bus.op_data2;
    rr = bus.rsp_resp; rt = bus.rsp_tag; rd = bus.rsp_data; rdy = bus.res_ready;
    @(posedge clk);
    cyc++;
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    e_unexp = 0;
    e_tmo = 0;
    if (rr != 0 && m_busy[rt]) begin
      r.tag = rt; r.cmd = m_cmd[rt]; r.resp = rr; r.data = rd;
      m_q.push_back(r);
      m_busy[rt] = 0;
    end else begin
      e_unexp = rr != 0;
      for (int t = 0; t < 4 && !e_tmo; t++)
        if (m_busy[t] && cyc - m_issue[t] > TMO) begin
          r.tag = 2'(t); r.cmd = m_cmd[t]; r.resp = 2'd3; r.data = '0;
          m_q.push_back(r);
          m_busy[t] = 0;
          e_tmo = 1;
        end
    end
    if (m_op2) begin
      {e_req_cmd, e_req_tag, e_req_data} = {4'd0, 2'd0, m_d2};
      m_op2 = 0;
    end else if (acc) begin
      {e_req_cmd, e_req_tag, e_req_data} = {c, 2'(tag), a};
      m_d2 = b;
      m_busy[tag] = 1;
      m_cmd[tag] = c;
      m_issue[tag] = cyc;
      m_op2 = 1;
    end else
      {e_req_cmd, e_req_tag, e_req_data} = '0;
    #1;
    head = m_q.size() > 0 ? m_q[0] : '0;
    chk("op_ready", bus.op_ready, m_ready());
    chk("req", {bus.req_cmd, bus.req_tag, bus.req_data}, {e_req_cmd, e_req_tag, e_req_data});
    chk("res_valid", bus.res_valid, m_q.size() > 0);
    chk("res_head", {bus.res_tag, bus.res_cmd, bus.res_resp, bus.res_data}, head);
    chk("outstanding", outstanding, n_busy());
    chk("err_unexpected", err_unexpected, e_unexp);
    chk("err_timeout", err_timeout, e_tmo);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 0;
    m_reset();
    @(posedge clk);
    #1;
    chk("rst_op_ready", bus.op_ready, 0);
    chk("rst_req", {bus.req_cmd, bus.req_tag, bus.req_data}, 0);
    chk("rst_res", {bus.res_valid, bus.res_tag, bus.res_cmd, bus.res_resp, bus.res_data}, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", {err_unexpected, err_timeout}, 0);
    reset = 1;
  endtask

  initial begin
    int n;
    logic [3:0] cmds [4];
    int order [4];
    cmds = '{4'd1, 4'd2, 4'd5, 4'd6};
    order = '{3, 0, 1, 2};
    vecs[0] = '{1, 4'd1, 5, 7, 0, 0, 0, 1, 0, 4'd1, 0, 5, 0, 0, 1, 0};
    vecs[1] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 7, 0, 0, 1, 0};
    vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    vecs[3] = '{0, 0, 0, 0, 1, 0, 12, 0, 1, 0, 0, 0, 1, 40'h050000000c, 0, 0};
    vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{0, 0, 0, 0, 1, 1, 9, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[6] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].ov, vecs[i].cmd, vecs[i].d1, vecs[i].d2, vecs[i].rr, vecs[i].rt, vecs[i].rd, vecs[i].rdy);
      step();
      chk("vec_op_ready", bus.op_ready, vecs[i].x_ordy);
      chk("vec_req", {bus.req_cmd, bus.req_tag, bus.req_data}, {vecs[i].x_rcmd, vecs[i].x_rtag, vecs[i].x_rdata});
      chk("vec_res", {bus.res_valid, bus.res_tag, bus.res_cmd, bus.res_resp, bus.res_data}, {vecs[i].x_rv, vecs[i].x_head});
      chk("vec_outstanding", outstanding, vecs[i].x_out);
      chk("vec_err_unexpected", err_unexpected, vecs[i].x_unexp);
    end

    // fill all four tags with the buffer stalled, then free one through a response
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 4'(i), $urandom, $urandom, 0, 0, 0, 0);
      step();
    end
    chk("full_outstanding", outstanding, 4);
    chk("full_op_ready", bus.op_ready, 0);
    drive(1, 4'd1, 1, 2, 1, 2, 32'hdead, 0);
    step();
    chk("credit_op_ready", bus.op_ready, 0);
    drive(1, 4'd1, 1, 2, 0, 0, 0, 1);
    step();
    chk("drained_op_ready", bus.op_ready, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (20) step();

    // out-of-order responses come out in arrival order with their own commands
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1, cmds[i / 2], $urandom, $urandom, 0, 0, 0, 0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 2'(order[i]), 32'(100 + order[i]), 0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      chk("ooo_tag", bus.res_tag, order[i]);
      chk("ooo_cmd", bus.res_cmd, cmds[order[i]]);
      chk("ooo_data", bus.res_data, 100 + order[i]);
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      step();
    end

    // timeout, tag reuse, and response winning over a same-cycle timeout
    do_reset();
    drive(1, 4'd2, 3, 4, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (!err_timeout && n < 30) begin
      step();
      n++;
    end
    chk("timeout_latency", n, TMO + 1);
    chk("timeout_result", {bus.res_valid, bus.res_tag, bus.res_cmd, bus.res_resp, bus.res_data}, {1'b1, 2'd0, 4'd2, 2'd3, 32'd0});
    drive(1, 4'd6, 11, 12, 0, 0, 0, 1);
    step();
    chk("reuse_tag", {bus.req_cmd, bus.req_tag}, {4'd6, 2'd0});
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (TMO) step();
    drive(0, 0, 0, 0, 1, 0, 32'h55, 0);
    step();
    chk("race_err_timeout", err_timeout, 0);
    chk("race_result", {bus.res_valid, bus.res_resp, bus.res_data}, {1'b1, 2'd1, 32'h55});
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (TMO + 3) step();
    chk("race_no_late_timeout", bus.res_valid, 0);

    // reset while in the second request cycle with two tags in flight
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'd1, 32'(i + 1), 32'(i + 2), 0, 0, 0, 0);
      step();
    end
    reset = 0;
    #1;
    chk("midrst_req", {bus.req_cmd, bus.req_tag, bus.req_data}, 0);
    chk("midrst_outstanding", outstanding, 0);
    chk("midrst_op_ready", bus.op_ready, 0);
    chk("midrst_res_valid", bus.res_valid, 0);
    m_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1;
    drive(1, 4'd5, 7, 8, 0, 0, 0, 1);
    step();
    chk("midrst_first_tag", {bus.req_cmd, bus.req_tag}, {4'd5, 2'd0});
    drive(0, 0, 0, 0, 1, 1, 32'h77, 1);
    step();
    chk("midrst_stale", err_unexpected, 1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int cands [$];
      logic [1:0] rr, rt;
      rr = 0;
      rt = 2'($urandom);
      for (int t = 0; t < 4; t++) if (m_busy[t]) cands.push_back(t);
      if ($urandom_range(0, 2) == 0) begin
        rr = 2'($urandom_range(1, 2));
        if (cands.size() > 0 && $urandom_range(0, 3) != 0) rt = 2'(cands[$urandom_range(0, cands.size() - 1)]);
      end
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) ? cmds[$urandom_range(0, 3)] : 4'($urandom),
            $urandom, $urandom, rr, rt, $urandom, $urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cal_req_initiator.md
Name: cal_req_initiator

Overview:
- Single-port request initiator for the four-port calculator; the other end of the calculator's request/response protocol.
- Accepts operations from an upstream valid/ready source and allocates a free 2-bit tag per operation.
- Drives the two-cycle calculator request sequence, then matches tagged responses back to outstanding operations.
- Delivers completed results downstream through a small buffer. Four instances (one per calculator port) form a hardware traffic generator/checker front end.

Parameters:
TIMEOUT, 100, cycles from request issue to response before an operation is declared lost
RES_DEPTH, 4, result buffer entries (minimum 4)

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  asynchronous, active-low reset
op_valid  input  1  upstream operation valid
op_ready  output  1  operation accepted on op_valid&op_ready at posedge
op_cmd  input  4  calculator command (1 add, 2 sub, 5 shl, 6 shr; others forwarded unchanged)
op_data1  input  32  operand 1
op_data2  input  32  operand 2
req_cmd  output  4  to calculator reqN_cmd_in
req_tag  output  2  to calculator reqN_tag_in
req_data  output  32  to calculator reqN_data_in
rsp_resp  input  2  from calculator out_respN (0 none, 1 ok, 2 overflow/invalid)
rsp_tag  input  2  from calculator out_tagN
rsp_data  input  32  from calculator out_dataN
res_valid  output  1  result available
res_ready  input  1  result consumed on res_valid&res_ready
res_tag  output  2  tag of result
res_cmd  output  4  original command
res_resp  output  2  response code; 3 = timeout
res_data  output  32  result data (0 on timeout)
outstanding  output  3  number of issued, unanswered tags (0..4)
err_unexpected  output  1  one-cycle pulse: response for tag not outstanding
err_timeout  output  1  one-cycle pulse: an operation timed out

Behaviour:
- Reset (reset=0, async): state IDLE; req_* = 0; outstanding mask and all tag timers cleared; FIFO empty; res_valid=0, res_*=0; op_ready=0; err_* = 0; outstanding=0.
- FSM IDLE / OP2. req_* are registered outputs.
- op_ready = (state==IDLE) & (free tag exists) & (outstanding + fifo_count < RES_DEPTH). This credit rule guarantees every response has buffer space; the calculator cannot be back-pressured.
- Accept edge in IDLE:
  - Allocate the lowest-numbered free tag.
  - Load req_cmd=op_cmd, req_tag=tag, req_data=op_data1.
  - Store op_cmd and op_data2; set outstanding[tag]; zero timer[tag]; go to OP2.
- OP2 edge: req_cmd=0, req_tag=0, req_data=stored op_data2; go to IDLE.
- IDLE edge with no accept: req_* = 0.
- Throughput is one operation per 2 cycles with no bubble between op2 and the next cmd.
- Allocation uses the registered mask. A tag freed in cycle N is allocatable from cycle N+1.
- Response capture (rsp_resp != 0, sampled at posedge):
  - If outstanding[rsp_tag] is set: push {tag, stored cmd, rsp_resp, rsp_data} into the FIFO; clear outstanding[rsp_tag] and its timer.
  - Otherwise: discard, and pulse err_unexpected in the next cycle.
- Timers:
  - timer[t] increments each cycle while outstanding[t], saturating at TIMEOUT.
  - On reaching TIMEOUT: push {t, cmd, 3, 0}, clear outstanding[t], pulse err_timeout.
  - Response and timeout for the same tag in the same cycle: the response wins.
- One FIFO push per cycle maximum.
  - Priority: response first, then the lowest expired tag.
  - Other expired tags stay saturated and are pushed on later cycles.
- FIFO (cal_res_fifo): show-ahead. res_* reflect the head entry; res_valid = !empty.
  - Simultaneous push and pop is allowed at any fill level, including full with a pop.
  - Credit rule makes push-when-full impossible; an assertion checks it.
- outstanding = popcount of the mask, updated the cycle after the event.
- Reset mid-operation: all in-flight state is discarded. Responses arriving after reset release are flagged unexpected.

Decomposition:
- Shared package cal_pkg:
  - cal_cmd_e (NOP=0, ADD=1, SUB=2, SHL=5, SHR=6)
  - cal_resp_e (NONE=0, OK=1, ERR=2, TIMEOUT=3)
  - TAG_W=2, DATA_W=32, CMD_W=4
  - struct cal_result_t {tag, cmd, resp, data}
- Sub-module cal_res_fifo: parameterised sync FIFO of cal_result_t, depth RES_DEPTH, async active-low reset.

Test Plan:
- Accept ADD data1=5 data2=7 from reset → cycle+1 req={1,tag0,5}, cycle+2 req={0,0,7}, cycle+3 req=0. Then rsp {1,tag0,12} → res_valid with tag0/cmd1/resp1/data12; outstanding 1→0.
- Five back-to-back ops with no responses and res_ready=0 → tags 0,1,2,3 issued every 2 cycles; op_ready stays 0 after the 4th; outstanding=4. Response for tag2 → op_ready returns only after the FIFO is drained below credit.
- Out-of-order responses for tags 3,0,1,2 → FIFO yields results in arrival order with correct cmd per tag.
- Response with tag 1 while only tag 0 is outstanding → err_unexpected pulses once; FIFO unchanged.
- TIMEOUT=8, no response → after 8 cycles err_timeout pulses; result is resp=3, data=0; tag reusable. Response and timeout on the same cycle → resp=1 result only.
- Reset asserted while in OP2 with 2 outstanding → all outputs 0 immediately. After release, the first op gets tag0, and a stale response produces err_unexpected.
